// File: rtl/envelope_defs.sv
// Shared definitions for the per-voice gain envelope: state encoding and
// widths of the gain and envelope step index seen by the dynamics stage.
package envelope_defs;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    localparam int GAIN_W     = 8;
    localparam int UNITY_GAIN = 128;
    localparam int ENV_IDX_W  = 6;

endpackage

// File: rtl/env_prescaler.sv
// Sample-strobe divider: raises step_tick on every STEP_SAMPLES-th enabled
// strobe. clr restarts the count from zero and takes priority over en.
module env_prescaler #(
    parameter int STEP_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic step_tick
);

    localparam int CNT_W = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_SAMPLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, wrap at the last strobe of a step, or advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Strobe counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_tick = en & (cnt_q == LAST);

endmodule

// File: rtl/envelope_sequencer.sv
// Per-note ADSR gain envelope. Produces the 8-bit gain (multiple) and the
// envelope step index for a voice's dynamics stage. Every output is a flop.
module envelope_sequencer
    import envelope_defs::*;
#(
    parameter int STEP_SAMPLES = 4,
    parameter int ATTACK_INC   = 32,
    parameter int DECAY_DEC    = 8,
    parameter int RELEASE_DEC  = 16,
    parameter int PEAK         = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 generate_next_sample,
    input  logic                 play,
    input  logic                 note_start,
    input  logic                 note_off,
    input  logic [GAIN_W-1:0]    sustain_level,
    output logic [GAIN_W-1:0]    multiple,
    output logic [ENV_IDX_W-1:0] env_idx,
    output logic                 new_note,
    output logic                 env_active,
    output logic                 env_done
);

    localparam logic [GAIN_W-1:0] PEAK_G  = GAIN_W'(PEAK);
    localparam logic [GAIN_W:0]   ATT_INC = (GAIN_W + 1)'(ATTACK_INC);
    localparam logic [GAIN_W:0]   DEC_DEC = (GAIN_W + 1)'(DECAY_DEC);
    localparam logic [GAIN_W:0]   REL_DEC = (GAIN_W + 1)'(RELEASE_DEC);

    // Add in 9 bits and clamp at ceil so a large step never wraps past it.
    function automatic logic [GAIN_W-1:0] sat_add(
        input logic [GAIN_W-1:0] g,
        input logic [GAIN_W:0]   inc,
        input logic [GAIN_W-1:0] ceil
    );
        logic [GAIN_W:0] sum;
        sum = {1'b0, g} + inc;
        return (sum >= {1'b0, ceil}) ? ceil : sum[GAIN_W-1:0];
    endfunction

    // Subtract with a floor; the comparison is done as g <= floor + dec so
    // the 9-bit intermediate never goes negative.
    function automatic logic [GAIN_W-1:0] sat_sub(
        input logic [GAIN_W-1:0] g,
        input logic [GAIN_W:0]   dec,
        input logic [GAIN_W-1:0] floor_g
    );
        logic [GAIN_W:0] diff;
        if ({1'b0, g} <= ({1'b0, floor_g} + dec)) begin
            return floor_g;
        end
        diff = {1'b0, g} - dec;
        return diff[GAIN_W-1:0];
    endfunction

    env_state_e            state_q, state_d;
    logic [GAIN_W-1:0]     mult_q, mult_d;
    logic [ENV_IDX_W-1:0]  idx_q, idx_d;
    logic                  new_note_q, new_note_d;
    logic                  env_done_q, env_done_d;
    logic                  env_active_q, env_active_d;

    logic                  strobe;
    logic                  step_tick;
    logic [GAIN_W-1:0]     sus_g;

    assign strobe = generate_next_sample & play;
    assign sus_g  = (sustain_level > PEAK_G) ? PEAK_G : sustain_level;

    env_prescaler #(
        .STEP_SAMPLES(STEP_SAMPLES)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (note_start),
        .en       (strobe),
        .step_tick(step_tick)
    );

    // Next-state and gain update: note_start, then note_off, then step actions.
    always_comb begin
        state_d      = state_q;
        mult_d       = mult_q;
        idx_d        = idx_q;
        new_note_d   = 1'b0;
        env_done_d   = 1'b0;

        if (note_start) begin
            // Retrigger ramps from the current gain, so mult is left alone.
            state_d    = ST_ATTACK;
            idx_d      = '0;
            new_note_d = 1'b1;
        end else begin
            if (step_tick && state_q != ST_IDLE && idx_q != '1) begin
                idx_d = idx_q + 1'b1;
            end

            if (note_off && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                             state_q == ST_SUSTAIN)) begin
                state_d = ST_RELEASE;
            end else if (step_tick) begin
                unique case (state_q)
                    ST_ATTACK: begin
                        mult_d = sat_add(mult_q, ATT_INC, PEAK_G);
                        if (mult_d == PEAK_G) state_d = ST_DECAY;
                    end
                    ST_DECAY: begin
                        mult_d = sat_sub(mult_q, DEC_DEC, sus_g);
                        if (mult_d == sus_g) state_d = ST_SUSTAIN;
                    end
                    ST_SUSTAIN: begin
                        mult_d = sus_g;
                    end
                    ST_RELEASE: begin
                        mult_d = sat_sub(mult_q, REL_DEC, '0);
                        if (mult_d == '0) begin
                            state_d    = ST_IDLE;
                            env_done_d = 1'b1;
                        end
                    end
                    default: begin
                        mult_d = '0;
                    end
                endcase
            end
        end

        env_active_d = (state_d != ST_IDLE);
    end

    // Envelope state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mult_q       <= '0;
            idx_q        <= '0;
            new_note_q   <= 1'b0;
            env_done_q   <= 1'b0;
            env_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mult_q       <= mult_d;
            idx_q        <= idx_d;
            new_note_q   <= new_note_d;
            env_done_q   <= env_done_d;
            env_active_q <= env_active_d;
        end
    end

    assign multiple   = mult_q;
    assign env_idx    = idx_q;
    assign new_note   = new_note_q;
    assign env_done   = env_done_q;
    assign env_active = env_active_q;

endmodule

// File: tb/tb_envelope_sequencer.sv
// Directed bench for envelope_sequencer with a cycle-level reference model
// feeding a scoreboard queue, plus spot checks of the documented gain ramps.
module tb_envelope_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       generate_next_sample;
    logic       play;
    logic       note_start;
    logic       note_off;
    logic [7:0] sustain_level;
    logic [7:0] multiple;
    logic [5:0] env_idx;
    logic       new_note;
    logic       env_active;
    logic       env_done;

    always #5 clk = ~clk;

    envelope_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .generate_next_sample(generate_next_sample),
        .play                (play),
        .note_start          (note_start),
        .note_off            (note_off),
        .sustain_level       (sustain_level),
        .multiple            (multiple),
        .env_idx             (env_idx),
        .new_note            (new_note),
        .env_active          (env_active),
        .env_done            (env_done)
    );

    typedef struct {
        int mult;
        int idx;
        int nn;
        int act;
        int done;
    } exp_t;

    exp_t sb_q[$];

    int vectors    = 0;
    int miscompares = 0;
    int done_cnt   = 0;

    // Reference model state: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
    int m_state = 0;
    int m_mult  = 0;
    int m_idx   = 0;
    int m_pre   = 0;
    int m_new   = 0;
    int m_done  = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int  s;
        bit  strb;
        bit  tk;
        s    = (sustain_level > 8'd128) ? 128 : int'(sustain_level);
        strb = generate_next_sample && play;
        tk   = strb && (m_pre == 3);
        if (rst) begin
            m_state = 0; m_mult = 0; m_idx = 0; m_pre = 0; m_new = 0; m_done = 0;
        end else begin
            m_new  = 0;
            m_done = 0;
            if (note_start) begin
                m_state = 1; m_pre = 0; m_idx = 0; m_new = 1;
            end else begin
                if (strb) m_pre = (m_pre == 3) ? 0 : m_pre + 1;
                if (tk && m_state != 0 && m_idx < 63) m_idx++;
                if (note_off && m_state >= 1 && m_state <= 3) begin
                    m_state = 4;
                end else if (tk) begin
                    case (m_state)
                        1: begin
                            m_mult = m_mult + 32;
                            if (m_mult >= 128) begin m_mult = 128; m_state = 2; end
                        end
                        2: begin
                            m_mult = m_mult - 8;
                            if (m_mult <= s) begin m_mult = s; m_state = 3; end
                        end
                        3: m_mult = s;
                        4: begin
                            m_mult = m_mult - 16;
                            if (m_mult <= 0) begin m_mult = 0; m_state = 0; m_done = 1; end
                        end
                        default: m_mult = 0;
                    endcase
                end
            end
        end
    endtask

    // Run n clock cycles, scoreboarding every output after each edge.
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            model_edge();
            e.mult = m_mult;
            e.idx  = m_idx;
            e.nn   = m_new;
            e.act  = (m_state != 0) ? 1 : 0;
            e.done = m_done;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            chk("sb_multiple",   int'(multiple),   e.mult);
            chk("sb_env_idx",    int'(env_idx),    e.idx);
            chk("sb_new_note",   int'(new_note),   e.nn);
            chk("sb_env_active", int'(env_active), e.act);
            chk("sb_env_done",   int'(env_done),   e.done);
            if (env_done) done_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; note_start = 1'b1; note_off = 1'b0;
        generate_next_sample = 1'b0; play = 1'b1; sustain_level = 8'd96;

        // Reset overrides a simultaneous note_start
        cyc(2);
        chk("rst_multiple", int'(multiple), 0);
        chk("rst_env_idx", int'(env_idx), 0);
        chk("rst_active", int'(env_active), 0);
        chk("rst_new_note", int'(new_note), 0);
        rst = 1'b0; note_start = 1'b0;
        cyc(1);

        // Attack / decay / sustain with strobe every cycle
        note_start = 1'b1; cyc(1); note_start = 1'b0;
        chk("ads_new_note", int'(new_note), 1);
        generate_next_sample = 1'b1;
        cyc(4);  chk("ads_att1", int'(multiple), 32);
        cyc(12); chk("ads_peak", int'(multiple), 128);
        cyc(4);  chk("ads_dec1", int'(multiple), 120);
        cyc(12); chk("ads_sus", int'(multiple), 96);
        chk("ads_idx", int'(env_idx), 8);
        cyc(8);  chk("ads_hold", int'(multiple), 96);

        // Release to zero
        generate_next_sample = 1'b0; note_off = 1'b1; cyc(1); note_off = 1'b0;
        chk("rel_active", int'(env_active), 1);
        generate_next_sample = 1'b1;
        done_cnt = 0;
        cyc(4);  chk("rel_step1", int'(multiple), 80);
        cyc(20); chk("rel_zero", int'(multiple), 0);
        chk("rel_done_once", done_cnt, 1);
        chk("rel_idle", int'(env_active), 0);

        // Retrigger during release at 48
        generate_next_sample = 1'b0; note_start = 1'b1; cyc(1); note_start = 1'b0;
        generate_next_sample = 1'b1; cyc(16);
        generate_next_sample = 1'b0; note_off = 1'b1; cyc(1); note_off = 1'b0;
        generate_next_sample = 1'b1; cyc(20);
        chk("retrig_from", int'(multiple), 48);
        generate_next_sample = 1'b0; note_start = 1'b1; cyc(1); note_start = 1'b0;
        chk("retrig_new_note", int'(new_note), 1);
        chk("retrig_idx", int'(env_idx), 0);
        chk("retrig_no_click", int'(multiple), 48);
        generate_next_sample = 1'b1;
        cyc(4); chk("retrig_a1", int'(multiple), 80);
        cyc(4); chk("retrig_a2", int'(multiple), 112);
        cyc(4); chk("retrig_a3", int'(multiple), 128);

        // note_start and note_off together: attack wins (release would give 112)
        generate_next_sample = 1'b0; note_start = 1'b1; note_off = 1'b1; cyc(1);
        note_start = 1'b0; note_off = 1'b0;
        chk("both_new_note", int'(new_note), 1);
        generate_next_sample = 1'b1; cyc(4);
        chk("both_attack", int'(multiple), 128);

        // Pause mid-attack
        rst = 1'b1; cyc(1); rst = 1'b0;
        generate_next_sample = 1'b0; note_start = 1'b1; cyc(1); note_start = 1'b0;
        generate_next_sample = 1'b1; cyc(6);
        chk("pause_pre", int'(multiple), 32);
        play = 1'b0;
        for (int i = 0; i < 100; i++) begin
            generate_next_sample = i[0];
            cyc(1);
        end
        chk("pause_mult", int'(multiple), 32);
        chk("pause_idx", int'(env_idx), 1);
        play = 1'b1; generate_next_sample = 1'b1;
        cyc(1); chk("resume_no_tick", int'(multiple), 32);
        cyc(1); chk("resume_tick", int'(multiple), 64);

        // Sustain above peak clamps: decay ends on its first tick at 128
        sustain_level = 8'd200;
        cyc(8); chk("clamp_peak", int'(multiple), 128);
        cyc(4); chk("clamp_sus", int'(multiple), 128);
        sustain_level = 8'd50;
        cyc(4); chk("sus_track", int'(multiple), 50);

        // Reset mid-decay at 112
        sustain_level = 8'd96;
        rst = 1'b1; cyc(1); rst = 1'b0;
        generate_next_sample = 1'b0; note_start = 1'b1; cyc(1); note_start = 1'b0;
        generate_next_sample = 1'b1; cyc(24);
        chk("mid_decay", int'(multiple), 112);
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("mid_rst_mult", int'(multiple), 0);
        chk("mid_rst_idx", int'(env_idx), 0);
        chk("mid_rst_active", int'(env_active), 0);
        note_off = 1'b1; cyc(1); note_off = 1'b0;
        chk("idle_off_active", int'(env_active), 0);
        cyc(8);
        chk("idle_off_mult", int'(multiple), 0);
        chk("idle_off_active2", int'(env_active), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
